fnd_digit_driver: RTL and testbench
===================================

// Module: fnd_digit_driver
// PURPOSE
//  Consumer side of the 2-bit FND scan select. Takes the free-running digit select
//  fnd_sel[1:0] and a 4-digit hex/BCD value, and drives the Basys3 4-digit common-anode
//  7-segment display. Adds the sequential behaviour needed for a clean display:
//   - anti-ghosting blanking after every select change;
//   - per-frame snapshot of the display data, so a frame never tears;
//   - leading-zero suppression.
//  Sits between the scan counter / stopwatch-watch datapath and the top-level FND pins.
// PARAMETERS
//  BLANK_CYCLES  4  clk periods all anodes are off after each fnd_sel change; legal range >= 1
//  CNT_W         $clog2(BLANK_CYCLES+1)  blank counter width (derived, do not override)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-high reset
//  fnd_sel    in   2   current digit select from scan counter, 0=rightmost digit
//  digit_in   in   16  4 nibbles, [3:0]=digit0 ... [15:12]=digit3, values 0..F
//  dp_in      in   4   decimal point per digit, 1 = lit, bit i -> digit i
//  lz_en      in   1   1 = suppress leading zeros
//  fnd_com    out  4   anode enables, active-low, bit i -> digit i
//  fnd_font   out  8   segments active-low: [7]=dp, [6:0]=g,f,e,d,c,b,a
//  frame_tick out  1   1-cycle pulse at each data snapshot
// BEHAVIOUR
//  Reset values: fnd_com=4'hF, fnd_font=8'hFF, frame_tick=0.
//   Internal: sel_q=0, shadow data/dp=0, state=BLANK, cnt=0.
//  All outputs are registered; nothing is combinational from input to output.
//  States: BLANK, DRIVE.
//  Change detect: at any edge where fnd_sel != sel_q (any state):
//   - sel_q<=fnd_sel, state<=BLANK, cnt<=0, fnd_com<=4'hF, fnd_font<=8'hFF.
//   - If fnd_sel==0 at that edge: shadow<=digit_in/dp_in, frame_tick<=1.
//   - Otherwise frame_tick<=0.
//  BLANK with no change: cnt<=cnt+1.
//   - When cnt==BLANK_CYCLES-1: state<=DRIVE, fnd_com<=~(4'b0001<<sel_q),
//     fnd_font<=font(sel_q).
//   - Net effect: anodes are off for exactly BLANK_CYCLES periods after the detecting edge.
//  DRIVE with no change: fnd_com/fnd_font are re-evaluated from shadow each edge.
//   Shadow only changes at a snapshot, so the outputs are stable within a frame.
//  A select change during BLANK restarts the blanking: cnt<=0, new sel_q.
//  Reset exit: sel_q=0 and state=BLANK, so if fnd_sel is held at 0 the first frame drives
//   digit0 from shadow=0 after BLANK_CYCLES cycles, with no frame_tick.
//   The first snapshot happens on the next 3->0 (or any ->0) change.
//  font(i): hex decode of shadow nibble i.
//   0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E
//   These values are with dp off. The dp bit is [7] = ~shadow_dp[i].
//  Leading-zero suppression (lz_en=1): a suppressed digit's [6:0] is 7'h7F; dp is still honoured.
//   - digit3 is blank if d3==0.
//   - digit2 is blank if d3==d2==0.
//   - digit1 is blank if d3..d1==0.
//   - digit0 is never blanked.
//   lz_en is sampled live, not snapshotted.
//  Async rst mid-frame: all outputs go to reset values immediately.
// STRUCTURE
//  Shared package fnd_pkg:
//   - state encoding (BLANK=1'b0, DRIVE=1'b1);
//   - SEG_OFF=8'hFF and COM_OFF=4'hF;
//   - the 16-entry hex font constant table.
//  Sub-module fnd_hex_font: combinational, 4-bit nibble + dp + blank -> 8-bit font.
//   Instantiated once on the muxed shadow nibble.
//  Top level holds sel_q, the blank counter/FSM, the shadow registers, the LZ logic
//   and the output registers.
// TESTING
//  1. Reset, hold fnd_sel=0 -> fnd_com=F, fnd_font=FF. BLANK_CYCLES=4: cycles later
//     fnd_com=4'b1110, fnd_font=C0, frame_tick never pulses.
//  2. digit_in=16'h1234, dp_in=0, lz_en=0; sequence fnd_sel 3->0 -> 1-cycle frame_tick.
//     After 4 blank cycles fnd_com=1110, font=99 ('4'). Then sel=1 -> com=1101, font=B0.
//  3. Change digit_in to 16'hABCD while fnd_sel=2 -> digits 2,3 still show 2,1 (A4, F9).
//     After the next ->0 change, digit0 shows d (A1).
//  4. lz_en=1, snapshot 16'h0005, dp_in=4'b0100 -> d3 font=FF, d2 font=7F (dp only),
//     d1 font=FF, d0 font=92.
//  5. Toggle fnd_sel 0->1->2 on consecutive cycles -> fnd_com stays F until 4 cycles
//     after the last change, then 1011.
//  6. Assert rst during DRIVE -> fnd_com=F, fnd_font=FF the same cycle.
//     Shadow cleared: next drive shows C0.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared types and constants for the Basys3 4-digit 7-segment display driver.
package fnd_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } fnd_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] COM_OFF = 4'hF;

  // Active-low hex glyphs with dp off; entry i holds the pattern for nibble value i.
  localparam logic [15:0][7:0] HEX_FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/fnd_hex_font.sv
// Combinational nibble-to-segment decoder with decimal point and blanking control.
module fnd_hex_font
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] font
);

  logic [7:0] glyph;

  always_comb begin
    glyph = HEX_FONT[nibble];
    font  = {~dp, (blank ? 7'h7F : glyph[6:0])};
  end

endmodule

// File: rtl/fnd_digit_driver.sv
// Scan-select consumer for the 4-digit common-anode display: blanking after every
// select change, per-frame data snapshot and optional leading-zero suppression.
module fnd_digit_driver
  import fnd_pkg::*;
#(
  parameter int BLANK_CYCLES = 4,
  parameter int CNT_W        = $clog2(BLANK_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  fnd_sel,
  input  logic [15:0] digit_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_font,
  output logic        frame_tick
);

  fnd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [3:0]       com_q, com_d;
  logic [7:0]       font_q, font_d;
  logic             tick_q, tick_d;

  logic [3:0]       cur_nibble;
  logic             cur_blank;
  logic [7:0]       cur_font;

  // Digit currently addressed by sel_q, plus live leading-zero decision.
  always_comb begin
    cur_nibble = shadow_q[3:0];
    cur_blank  = 1'b0;
    case (sel_q)
      2'd0: cur_nibble = shadow_q[3:0];
      2'd1: cur_nibble = shadow_q[7:4];
      2'd2: cur_nibble = shadow_q[11:8];
      2'd3: cur_nibble = shadow_q[15:12];
      default: cur_nibble = shadow_q[3:0];
    endcase
    case (sel_q)
      2'd1: cur_blank = lz_en && (shadow_q[15:4] == 12'h000);
      2'd2: cur_blank = lz_en && (shadow_q[15:8] == 8'h00);
      2'd3: cur_blank = lz_en && (shadow_q[15:12] == 4'h0);
      default: cur_blank = 1'b0;
    endcase
  end

  fnd_hex_font u_font (
    .nibble (cur_nibble),
    .dp     (shadow_dp_q[sel_q]),
    .blank  (cur_blank),
    .font   (cur_font)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    com_d       = com_q;
    font_d      = font_q;
    tick_d      = 1'b0;

    if (fnd_sel != sel_q) begin
      sel_d   = fnd_sel;
      state_d = ST_BLANK;
      cnt_d   = '0;
      com_d   = COM_OFF;
      font_d  = SEG_OFF;
      // Digit 0 starts a new frame: latch the whole value so the frame cannot tear.
      if (fnd_sel == 2'd0) begin
        shadow_d    = digit_in;
        shadow_dp_d = dp_in;
        tick_d      = 1'b1;
      end
    end else if (state_q == ST_BLANK) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
        state_d = ST_DRIVE;
        com_d   = ~(4'b0001 << sel_q);
        font_d  = cur_font;
      end
    end else begin
      com_d  = ~(4'b0001 << sel_q);
      font_d = cur_font;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BLANK;
      cnt_q       <= '0;
      sel_q       <= 2'd0;
      shadow_q    <= 16'h0000;
      shadow_dp_q <= 4'h0;
      com_q       <= COM_OFF;
      font_q      <= SEG_OFF;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      com_q       <= com_d;
      font_q      <= font_d;
      tick_q      <= tick_d;
    end
  end

  assign fnd_com    = com_q;
  assign fnd_font   = font_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_fnd_digit_driver.sv
// Directed-vector bench for fnd_digit_driver with BLANK_CYCLES = 4.
module tb_fnd_digit_driver;

  logic        clk;
  logic        rst;
  logic [1:0]  fnd_sel;
  logic [15:0] digit_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_font;
  logic        frame_tick;

  int n_checks;
  int n_fail;

  fnd_digit_driver #(.BLANK_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .fnd_sel    (fnd_sel),
    .digit_in   (digit_in),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .fnd_com    (fnd_com),
    .fnd_font   (fnd_font),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fnd_sel = 2'd0; digit_in = 16'h0000; dp_in = 4'h0; lz_en = 1'b0;
    tick(); tick();
    n_checks++; if (fnd_com !== 4'hF) begin n_fail++; $display("FAIL rst_com: got %h expected %h", fnd_com, 4'hF); end
    n_checks++; if (fnd_font !== 8'hFF) begin n_fail++; $display("FAIL rst_font: got %h expected %h", fnd_font, 8'hFF); end
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick: got %b expected %b", frame_tick, 1'b0); end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++; if (fnd_com !== 4'hF) begin n_fail++; $display("FAIL exit_blank_com[%0d]: got %h expected %h", i, fnd_com, 4'hF); end
      n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL exit_tick[%0d]: got %b expected %b", i, frame_tick, 1'b0); end
    end
    tick();
    n_checks++; if (fnd_com !== 4'b1110) begin n_fail++; $display("FAIL exit_com: got %h expected %h", fnd_com, 4'b1110); end
    n_checks++; if (fnd_font !== 8'hC0) begin n_fail++; $display("FAIL exit_font: got %h expected %h", fnd_font, 8'hC0); end
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL exit_tick_drv: got %b expected %b", frame_tick, 1'b0); end
  endtask

  task automatic test_snapshot();
    digit_in = 16'h1234; dp_in = 4'h0; lz_en = 1'b0;
    fnd_sel = 2'd3; tick();
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL snap_tick_s3: got %b expected %b", frame_tick, 1'b0); end
    fnd_sel = 2'd0; tick();
    n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL snap_tick: got %b expected %b", frame_tick, 1'b1); end
    n_checks++; if (fnd_com !== 4'hF) begin n_fail++; $display("FAIL snap_com_blank: got %h expected %h", fnd_com, 4'hF); end
    tick();
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL snap_tick_width: got %b expected %b", frame_tick, 1'b0); end
    n_checks++; if (fnd_com !== 4'hF) begin n_fail++; $display("FAIL snap_com_blank1: got %h expected %h", fnd_com, 4'hF); end
    repeat (3) tick();
    n_checks++; if (fnd_com !== 4'b1110) begin n_fail++; $display("FAIL d0_com: got %h expected %h", fnd_com, 4'b1110); end
    n_checks++; if (fnd_font !== 8'h99) begin n_fail++; $display("FAIL d0_font: got %h expected %h", fnd_font, 8'h99); end
    fnd_sel = 2'd1; tick();
    n_checks++; if (fnd_com !== 4'hF) begin n_fail++; $display("FAIL d1_blank: got %h expected %h", fnd_com, 4'hF); end
    repeat (4) tick();
    n_checks++; if (fnd_com !== 4'b1101) begin n_fail++; $display("FAIL d1_com: got %h expected %h", fnd_com, 4'b1101); end
    n_checks++; if (fnd_font !== 8'hB0) begin n_fail++; $display("FAIL d1_font: got %h expected %h", fnd_font, 8'hB0); end
  endtask

  task automatic test_no_tearing();
    fnd_sel = 2'd2; tick();
    digit_in = 16'hABCD;
    repeat (4) tick();
    n_checks++; if (fnd_com !== 4'b1011) begin n_fail++; $display("FAIL tear_d2_com: got %h expected %h", fnd_com, 4'b1011); end
    n_checks++; if (fnd_font !== 8'hA4) begin n_fail++; $display("FAIL tear_d2_font: got %h expected %h", fnd_font, 8'hA4); end
    fnd_sel = 2'd3; tick();
    repeat (4) tick();
    n_checks++; if (fnd_com !== 4'b0111) begin n_fail++; $display("FAIL tear_d3_com: got %h expected %h", fnd_com, 4'b0111); end
    n_checks++; if (fnd_font !== 8'hF9) begin n_fail++; $display("FAIL tear_d3_font: got %h expected %h", fnd_font, 8'hF9); end
    fnd_sel = 2'd0; tick();
    n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL tear_tick: got %b expected %b", frame_tick, 1'b1); end
    repeat (4) tick();
    n_checks++; if (fnd_com !== 4'b1110) begin n_fail++; $display("FAIL new_d0_com: got %h expected %h", fnd_com, 4'b1110); end
    n_checks++; if (fnd_font !== 8'hA1) begin n_fail++; $display("FAIL new_d0_font: got %h expected %h", fnd_font, 8'hA1); end
  endtask

  task automatic test_lz();
    lz_en = 1'b1; digit_in = 16'h0005; dp_in = 4'b0100;
    fnd_sel = 2'd3; tick();
    fnd_sel = 2'd0; tick();
    repeat (4) tick();
    n_checks++; if (fnd_font !== 8'h92) begin n_fail++; $display("FAIL lz_d0_font: got %h expected %h", fnd_font, 8'h92); end
    fnd_sel = 2'd1; tick(); repeat (4) tick();
    n_checks++; if (fnd_com !== 4'b1101) begin n_fail++; $display("FAIL lz_d1_com: got %h expected %h", fnd_com, 4'b1101); end
    n_checks++; if (fnd_font !== 8'hFF) begin n_fail++; $display("FAIL lz_d1_font: got %h expected %h", fnd_font, 8'hFF); end
    fnd_sel = 2'd2; tick(); repeat (4) tick();
    n_checks++; if (fnd_font !== 8'h7F) begin n_fail++; $display("FAIL lz_d2_font: got %h expected %h", fnd_font, 8'h7F); end
    fnd_sel = 2'd3; tick(); repeat (4) tick();
    n_checks++; if (fnd_com !== 4'b0111) begin n_fail++; $display("FAIL lz_d3_com: got %h expected %h", fnd_com, 4'b0111); end
    n_checks++; if (fnd_font !== 8'hFF) begin n_fail++; $display("FAIL lz_d3_font: got %h expected %h", fnd_font, 8'hFF); end
  endtask

  task automatic test_back_to_back();
    fnd_sel = 2'd0; tick();
    fnd_sel = 2'd1; tick();
    n_checks++; if (fnd_com !== 4'hF) begin n_fail++; $display("FAIL b2b_com_mid: got %h expected %h", fnd_com, 4'hF); end
    fnd_sel = 2'd2; tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++; if (fnd_com !== 4'hF) begin n_fail++; $display("FAIL b2b_blank[%0d]: got %h expected %h", i, fnd_com, 4'hF); end
    end
    tick();
    n_checks++; if (fnd_com !== 4'b1011) begin n_fail++; $display("FAIL b2b_com: got %h expected %h", fnd_com, 4'b1011); end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (fnd_com !== 4'hF) begin n_fail++; $display("FAIL arst_com: got %h expected %h", fnd_com, 4'hF); end
    n_checks++; if (fnd_font !== 8'hFF) begin n_fail++; $display("FAIL arst_font: got %h expected %h", fnd_font, 8'hFF); end
    fnd_sel = 2'd0; lz_en = 1'b0;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    n_checks++; if (fnd_com !== 4'b1110) begin n_fail++; $display("FAIL arst_d0_com: got %h expected %h", fnd_com, 4'b1110); end
    n_checks++; if (fnd_font !== 8'hC0) begin n_fail++; $display("FAIL arst_d0_font: got %h expected %h", fnd_font, 8'hC0); end
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL arst_tick: got %b expected %b", frame_tick, 1'b0); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_snapshot();
    test_no_tearing();
    test_lz();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
